// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single-bit full adder built from two half-adder stages and an OR of their carries.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic h1_sum_s;
    logic h1_carry_s;
    logic h2_carry_s;

    assign h1_sum_s   = x ^ y;
    assign h1_carry_s = x & y;
    assign s          = h1_sum_s ^ ci;
    assign h2_carry_s = h1_sum_s & ci;
    assign co         = h1_carry_s | h2_carry_s;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice processes operands LSB first.
// Optional subtract mode (input port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic             fa_s_s;
    logic             fa_co_s;

    fa_bit u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (c_q),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Operand B and carry-in as loaded at start; subtraction is a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load_s = ~b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = b;
            c_load_s = cin;
        end
`else
        b_load_s = b;
        c_load_s = cin;
`endif
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b_load_s;
                    c_d     = c_load_s;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = fa_co_s;
                sum_d = {fa_s_s, sum_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cout_d  = fa_co_s;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl at WIDTH=8 (subtract vectors under SERIAL_ADD_SUB_EN).
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic       vsub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         sub_i;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation: start at edge 0, optional second start pulse at cycle k2 with other operands.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic tcin, input logic tsub, input logic [7:0] exp_sum,
                          input logic exp_cout, input int k2, input logic [7:0] a2,
                          input logic [7:0] b2);
        int lat;
        int ndone;
        int busy_cnt;
        logic [7:0] sum_at_done;
        logic       cout_at_done;
        lat = -1;
        ndone = 0;
        busy_cnt = 0;
        sum_at_done = 8'h00;
        cout_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1; a_i = ta; b_i = tbv; cin_i = tcin; sub_i = tsub;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; a_i = ~ta; b_i = ~tbv; cin_i = ~tcin; sub_i = ~tsub;
                check({tag, " sum_clear"}, {56'd0, sum}, 64'd0);
                check({tag, " cout_clear"}, {63'd0, cout}, 64'd0);
            end
            if (k == k2) begin
                start = 1'b1; a_i = a2; b_i = b2;
            end
            if (k == k2 + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    sum_at_done = sum;
                    cout_at_done = cout;
                end
            end
            if (lat >= 0 && k == lat + 2) begin
                check({tag, " sum_hold"}, {56'd0, sum}, {56'd0, sum_at_done});
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(W + 1));
        check({tag, " done_count"}, 64'(ndone), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, " sum"}, {56'd0, sum_at_done}, {56'd0, exp_sum});
        check({tag, " cout"}, {63'd0, cout_at_done}, {63'd0, exp_cout});
    endtask

    initial begin
        int d1;
        int d2;
        logic [7:0] s1;
        logic [7:0] s2;
        logic saw_done;

        vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
        vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
`endif

        rst_n = 1'b0; start = 1'b0; a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0; sub_i = 1'b0;
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset sum", {56'd0, sum}, 64'd0);
        check("reset cout", {63'd0, cout}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                   vecs[i].exp_sum, vecs[i].exp_cout, -1, 8'h00, 8'h00);
        end

        // Second start during RUN must be ignored.
        run_op("start_ignored", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 3, 8'hAA, 8'h55);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; a_i = 8'h33; b_i = 8'h44; cin_i = 1'b0; sub_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort busy_before", {63'd0, busy}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort sum", {56'd0, sum}, 64'd0);
        check("abort cout", {63'd0, cout}, 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", {63'd0, saw_done}, 64'd0);
        run_op("after_reset", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, -1, 8'h00, 8'h00);

        // Start held high: back-to-back operations, each at full latency.
        d1 = -1; d2 = -1; s1 = 8'h00; s2 = 8'h00;
        @(negedge clk);
        start = 1'b1; a_i = 8'h03; b_i = 8'h04; cin_i = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k; s1 = sum;
                end else if (d2 < 0) begin
                    d2 = k; s2 = sum;
                end
            end
        end
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("b2b first_done", 64'(d1), 64'(W + 1));
        check("b2b second_done", 64'(d2), 64'(2 * W + 3));
        check("b2b first_sum", {56'd0, s1}, 64'h07);
        check("b2b second_sum", {56'd0, s2}, 64'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
